// File: rtl/pixel_pkg.sv
// Shared types and defaults for the pixel row readout sequencer.
package pixel_pkg;

  localparam int EXPOSE_W          = 16;
  localparam int ERASE_CYCLES_DEF  = 4;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int ADC_TIMEOUT_DEF   = 64;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    SETTLE,
    CONVERT,
    OUTPUT,
    DONE
  } state_t;

endpackage

// File: rtl/pixel_row_readout_ctrl_if.sv
// Result stream from the readout sequencer to the downstream consumer.
interface pixel_row_readout_ctrl_if #(
  parameter int WIDTH      = 2,
  parameter int RESOLUTION = 8
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [RESOLUTION-1:0] out_data;
  logic [WIDTH-1:0]      out_row;
  logic                  out_last;
  logic                  out_err;

  modport master (
    output out_valid, out_data, out_row, out_last, out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_last, out_err,
    output out_ready
  );

endinterface

// File: rtl/pixel_row_readout_ctrl_phase_timer.sv
// Loadable down-counter with zero flag; times the erase, expose, settle and timeout intervals.
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pixel_row_readout_ctrl.sv
// Frame sequencer: erase, expose, then per-row settle / ADC convert / stream out.
module pixel_row_readout_ctrl
  import pixel_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int ROWS          = 2,
  parameter int RESOLUTION    = 8,
  parameter int ERASE_CYCLES  = ERASE_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int ADC_TIMEOUT   = ADC_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [EXPOSE_W-1:0]   cfg_expose_cycles,
  output logic                  busy,
  output logic                  erase,
  output logic                  expose,
  output logic [WIDTH-1:0]      decoder_select,
  output logic                  adc_reset,
  output logic                  adc_enable,
  input  logic [RESOLUTION-1:0] adc_data,
  input  logic                  adc_done,
  pixel_row_readout_ctrl_if.master stream
);

  state_t              state, state_nx;
  logic [EXPOSE_W-1:0] expose_len;
  logic [WIDTH-1:0]    row;
  logic                row_last;
  logic                tmr_load;
  logic [EXPOSE_W-1:0] tmr_value;
  logic [EXPOSE_W-1:0] tmr_count;
  logic                tmr_zero;
  logic                conv_first;
  logic                done_hit;
  logic                capture;

  phase_timer #(.W(EXPOSE_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .count (tmr_count),
    .zero  (tmr_zero)
  );

  assign row_last = (row == WIDTH'(ROWS - 1));
  // The timeout load value marks the first CONVERT cycle, where adc_done is not trusted.
  assign conv_first = (tmr_count == EXPOSE_W'(ADC_TIMEOUT - 1));
  assign done_hit   = adc_done && !conv_first;

  always_comb begin
    state_nx  = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
    capture   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx  = ERASE;
        tmr_load  = 1'b1;
        tmr_value = EXPOSE_W'(ERASE_CYCLES - 1);
      end
      ERASE: if (tmr_zero) begin
        state_nx  = EXPOSE;
        tmr_load  = 1'b1;
        tmr_value = expose_len - EXPOSE_W'(1);
      end
      EXPOSE: if (tmr_zero) begin
        state_nx  = SETTLE;
        tmr_load  = 1'b1;
        tmr_value = EXPOSE_W'(SETTLE_CYCLES - 1);
      end
      SETTLE: if (tmr_zero) begin
        state_nx  = CONVERT;
        tmr_load  = 1'b1;
        tmr_value = EXPOSE_W'(ADC_TIMEOUT - 1);
      end
      CONVERT: if (done_hit || tmr_zero) begin
        state_nx = OUTPUT;
        capture  = 1'b1;
      end
      OUTPUT: if (stream.out_ready) begin
        if (row_last) begin
          state_nx = DONE;
        end else begin
          state_nx  = SETTLE;
          tmr_load  = 1'b1;
          tmr_value = EXPOSE_W'(SETTLE_CYCLES - 1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      expose_len      <= '0;
      row             <= '0;
      stream.out_data <= '0;
      stream.out_row  <= '0;
      stream.out_last <= 1'b0;
      stream.out_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        expose_len <= (cfg_expose_cycles == '0) ? EXPOSE_W'(1) : cfg_expose_cycles;
      end
      if (state == EXPOSE && tmr_zero) begin
        row <= '0;
      end else if (state == OUTPUT && stream.out_ready && !row_last) begin
        row <= row + WIDTH'(1);
      end
      if (capture) begin
        stream.out_data <= done_hit ? adc_data : '0;
        stream.out_err  <= !done_hit;
        stream.out_row  <= row;
        stream.out_last <= row_last;
      end
    end
  end

  assign busy             = (state != IDLE);
  assign erase            = (state == ERASE);
  assign expose           = (state == EXPOSE);
  assign decoder_select   = (state == SETTLE || state == CONVERT || state == OUTPUT) ? row : '0;
  assign adc_reset        = (state == SETTLE) && tmr_zero;
  assign adc_enable       = (state == CONVERT);
  assign stream.out_valid = (state == OUTPUT);

endmodule
